// File: rtl/branch_predictor.sv
// Branch predict (IF, direct-mapped saturating-counter table) and resolve/train (EX) unit.
// Optional PRED_STATS_EN adds saturating control-flow and mispredict counters.
module branch_predictor #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned BHT_DEPTH = 64,
    parameter int unsigned CNT_W     = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_is_branch,
    input  logic            ex_is_jal,
    input  logic            ex_is_jalr,
    input  logic            ex_cmp_res,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            do_branch,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc
`ifdef PRED_STATS_EN
    ,
    output logic [31:0]     stat_cf,
    output logic [31:0]     stat_miss
`endif
);

    localparam int unsigned IDX_W = $clog2(BHT_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);

    logic [CNT_W-1:0]     cnt_q [BHT_DEPTH];
    logic [XLEN-1:0]      tgt_q [BHT_DEPTH];
    logic [BHT_DEPTH-1:0] vld_q;

    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic             ex_cf;
    logic [CNT_W-1:0] cnt_d;

    assign if_idx = if_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_cf  = ex_valid & (ex_is_branch | ex_is_jal | ex_is_jalr);

    // IF-stage lookup reads the registered table, so a same-cycle EX write is not visible
    always_comb begin
        pred_taken  = if_valid & vld_q[if_idx] & cnt_q[if_idx][CNT_W-1];
        pred_target = pred_taken ? tgt_q[if_idx] : if_pc + XLEN'(4);
    end

    always_comb begin
        do_branch   = ex_valid & ((ex_is_branch & ex_cmp_res) | ex_is_jal | ex_is_jalr);
        mispredict  = ex_valid & ((do_branch != ex_pred_taken) |
                                  (do_branch & (ex_pred_target != ex_target)));
        redirect_pc = do_branch ? ex_target : ex_pc + XLEN'(4);
    end

    // Unconditional jumps win over a simultaneously flagged conditional branch
    always_comb begin
        cnt_d = cnt_q[ex_idx];
        if (ex_is_jalr || ex_is_jal) begin
            cnt_d = CNT_MAX;
        end else if (do_branch) begin
            if (cnt_q[ex_idx] != CNT_MAX) cnt_d = cnt_q[ex_idx] + CNT_W'(1);
        end else begin
            if (cnt_q[ex_idx] != '0) cnt_d = cnt_q[ex_idx] - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
                cnt_q[i] <= CNT_INIT;
                tgt_q[i] <= '0;
            end
            vld_q <= '0;
        end else if (ex_cf) begin
            cnt_q[ex_idx] <= cnt_d;
            vld_q[ex_idx] <= 1'b1;
            if (do_branch) tgt_q[ex_idx] <= ex_target;
        end
    end

`ifdef PRED_STATS_EN
    logic [31:0] stat_cf_q;
    logic [31:0] stat_miss_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_cf_q   <= '0;
            stat_miss_q <= '0;
        end else begin
            if (ex_cf && (stat_cf_q != '1))        stat_cf_q   <= stat_cf_q + 32'd1;
            if (mispredict && (stat_miss_q != '1)) stat_miss_q <= stat_miss_q + 32'd1;
        end
    end

    assign stat_cf   = stat_cf_q;
    assign stat_miss = stat_miss_q;
`endif

endmodule
